// File: rtl/score_keeper.sv
// score_keeper: edge-detected score/ball keeper producing digit codes for the text renderer
module score_keeper #(
  parameter int BALLS_INIT = 3,
  parameter int BONUS_TENS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hit,
  input  logic       bonus,
  input  logic       miss,
  input  logic       new_game,
  output logic [4:0] dig0,
  output logic [4:0] dig1,
  output logic [4:0] dig,
  output logic       game_over,
  output logic       score_tick
);
  typedef enum logic {PLAY, OVER} state_t;
  localparam logic [3:0] BI = 4'(BALLS_INIT);
  localparam logic [4:0] BT = 5'(BONUS_TENS);
  state_t     state_q, state_d;
  logic       hit_q, bonus_q, miss_q, ng_q;
  logic       hit_e, bonus_e, miss_e, ng_e;
  logic [3:0] ones_q, ones_d, tens_q, tens_d, balls_q, balls_d;
  logic       tick_q, tick_d;
  logic [4:0] ones_sum, tens_sum;
  logic [3:0] ones_n;
  logic       carry, sat;
  assign hit_e      = hit & ~hit_q;
  assign bonus_e    = bonus & ~bonus_q;
  assign miss_e     = miss & ~miss_q;
  assign ng_e       = new_game & ~ng_q;
  assign dig0       = {1'b1, ones_q};
  assign dig1       = {1'b1, tens_q};
  assign dig        = {1'b1, balls_q};
  assign game_over  = (state_q == OVER);
  assign score_tick = tick_q;
  // BCD add with ones-to-tens carry, saturating at 99, plus ball/state bookkeeping
  always_comb begin
    ones_sum = {1'b0, ones_q} + {4'b0, hit_e};
    carry    = ones_sum > 5'd9;
    ones_n   = carry ? 4'(ones_sum - 5'd10) : ones_sum[3:0];
    tens_sum = {1'b0, tens_q} + {4'b0, carry} + (bonus_e ? BT : 5'd0);
    sat      = tens_sum > 5'd9;
    state_d  = state_q;
    ones_d   = ones_q;
    tens_d   = tens_q;
    balls_d  = balls_q;
    tick_d   = 1'b0;
    if (ng_e) begin
      ones_d  = 4'd0;
      tens_d  = 4'd0;
      balls_d = BI;
      state_d = PLAY;
    end else if (state_q == PLAY) begin
      ones_d = sat ? 4'd9 : ones_n;
      tens_d = sat ? 4'd9 : tens_sum[3:0];
      tick_d = {tens_d, ones_d} != {tens_q, ones_q};
      if (miss_e && balls_q != 4'd0) begin
        balls_d = balls_q - 4'd1;
        state_d = (balls_q == 4'd1) ? OVER : PLAY;
      end
    end
  end
  // Strobe history, game state and score registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q   <= 1'b0;
      bonus_q <= 1'b0;
      miss_q  <= 1'b0;
      ng_q    <= 1'b0;
      state_q <= PLAY;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      balls_q <= BI;
      tick_q  <= 1'b0;
    end else begin
      hit_q   <= hit;
      bonus_q <= bonus;
      miss_q  <= miss;
      ng_q    <= new_game;
      state_q <= state_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      balls_q <= balls_d;
      tick_q  <= tick_d;
    end
  end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: table, directed and randomized checks of score_keeper against an arithmetic model
module tb_score_keeper;
  localparam int BI = 3;
  localparam int BT = 1;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic hit = 1'b0, bonus = 1'b0, miss = 1'b0, new_game = 1'b0;
  logic [4:0] dig0, dig1, dig;
  logic game_over, score_tick;
  int n_chk = 0;
  int n_err = 0;
  int m_score, m_balls;
  bit m_over, m_tick, ph, pb, pm, pn;
  typedef struct {
    bit h, b, m, n;
    int s, bl;
    bit o, t;
  } vec_t;
  vec_t tbl[13];

  score_keeper #(.BALLS_INIT(BI), .BONUS_TENS(BT)) dut (
    .clk(clk), .reset_n(reset_n), .hit(hit), .bonus(bonus), .miss(miss),
    .new_game(new_game), .dig0(dig0), .dig1(dig1), .dig(dig),
    .game_over(game_over), .score_tick(score_tick)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_score = 0; m_balls = BI; m_over = 0; m_tick = 0;
    ph = 0; pb = 0; pm = 0; pn = 0;
  endtask

  task automatic model_step(input bit h, b, m, n);
    bit eh, eb, em, en;
    int ns;
    eh = h & !ph; eb = b & !pb; em = m & !pm; en = n & !pn;
    ph = h; pb = b; pm = m; pn = n;
    m_tick = 0;
    if (en) begin
      m_score = 0; m_balls = BI; m_over = 0;
    end else if (!m_over) begin
      ns = m_score + (eh ? 1 : 0) + (eb ? 10 * BT : 0);
      if (ns > 99) ns = 99;
      m_tick = (ns != m_score);
      m_score = ns;
      if (em) begin
        m_balls = m_balls - 1;
        if (m_balls == 0) m_over = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input int s, input int bl, input bit o, input bit t);
    logic [4:0] e1, e0, eb;
    e1 = 5'h10 | 5'(s / 10);
    e0 = 5'h10 | 5'(s % 10);
    eb = 5'h10 | 5'(bl);
    n_chk++;
    if (dig1 !== e1 || dig0 !== e0 || dig !== eb || game_over !== o || score_tick !== t) begin
      n_err++;
      $display("FAIL %s: got dig1=%h dig0=%h dig=%h go=%b tick=%b, want dig1=%h dig0=%h dig=%h go=%b tick=%b",
               nm, dig1, dig0, dig, game_over, score_tick, e1, e0, eb, o, t);
    end
  endtask

  task automatic cyc(input bit h, b, m, n);
    hit = h; bonus = b; miss = m; new_game = n;
    @(posedge clk);
    model_step(h, b, m, n);
    @(negedge clk);
  endtask

  task automatic do_reset();
    hit = 0; bonus = 0; miss = 0; new_game = 0;
    reset_n = 0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset_n = 1;
  endtask

  task automatic pulses(input int k, input bit h, b, m);
    for (int i = 0; i < k; i++) begin
      cyc(h, b, m, 0);
      cyc(0, 0, 0, 0);
    end
  endtask

  initial begin
    tbl[0]  = '{0,0,0,0,  0,3,0,0};
    tbl[1]  = '{1,0,0,0,  1,3,0,1};
    tbl[2]  = '{1,0,0,0,  1,3,0,0};
    tbl[3]  = '{0,0,0,0,  1,3,0,0};
    tbl[4]  = '{0,1,0,0, 11,3,0,1};
    tbl[5]  = '{1,1,0,0, 12,3,0,1};
    tbl[6]  = '{0,0,0,0, 12,3,0,0};
    tbl[7]  = '{0,0,1,0, 12,2,0,0};
    tbl[8]  = '{1,1,1,0, 23,2,0,1};
    tbl[9]  = '{0,0,0,0, 23,2,0,0};
    tbl[10] = '{0,0,0,1,  0,3,0,0};
    tbl[11] = '{1,0,1,1,  1,2,0,1};
    tbl[12] = '{0,0,0,0,  1,2,0,0};

    do_reset();
    chk("reset_values", 0, BI, 0, 0);
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].h, tbl[i].b, tbl[i].m, tbl[i].n);
      chk($sformatf("table_%0d", i), tbl[i].s, tbl[i].bl, tbl[i].o, tbl[i].t);
    end

    do_reset();
    cyc(1, 0, 0, 0);
    chk("hit_held_first", 1, 3, 0, 1);
    for (int i = 1; i < 50; i++) begin
      cyc(1, 0, 0, 0);
      chk("hit_held", 1, 3, 0, 0);
    end
    cyc(0, 0, 0, 0);

    do_reset();
    pulses(9, 1, 0, 0);
    chk("score_09", 9, 3, 0, 0);
    cyc(1, 1, 0, 0);
    chk("09_hit_bonus", 20, 3, 0, 1);
    cyc(0, 0, 0, 0);
    pulses(7, 0, 1, 0);
    pulses(5, 1, 0, 0);
    chk("score_95", 95, 3, 0, 0);
    cyc(0, 1, 0, 0);
    chk("95_bonus_sat", 99, 3, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("99_hit_no_tick", 99, 3, 0, 0);
    cyc(0, 0, 0, 0);

    do_reset();
    cyc(0, 0, 1, 0); chk("miss_1", 0, 2, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); chk("miss_2", 0, 1, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); chk("miss_3_over", 0, 0, 1, 0); cyc(0, 0, 0, 0);
    cyc(1, 1, 1, 0); chk("over_ignores", 0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    do_reset();
    pulses(7, 1, 0, 0);
    pulses(2, 0, 0, 1);
    chk("score7_ball1", 7, 1, 0, 0);
    cyc(1, 0, 1, 0);
    chk("hit_with_last_miss", 8, 0, 1, 1);
    cyc(0, 0, 0, 0);

    do_reset();
    pulses(4, 0, 1, 0);
    pulses(2, 1, 0, 0);
    pulses(3, 0, 0, 1);
    chk("over_42", 42, 0, 1, 0);
    cyc(1, 0, 0, 1);
    chk("new_game_wins", 0, 3, 0, 0);
    cyc(0, 0, 0, 0);
    chk("after_new_game", 0, 3, 0, 0);

    pulses(3, 1, 0, 1);
    #2 reset_n = 0;
    #1 chk("async_reset", 0, BI, 0, 0);
    @(negedge clk);
    model_reset();
    reset_n = 1;

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 6) == 0, $urandom_range(0, 59) == 0);
      chk("random", m_score, m_balls, m_over, m_tick);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
